// File: rtl/regfile_pkg.sv
// Shared constants for the GPR file and HI/LO registers.
// Widths, enable levels, zero word and register count.
package regfile_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 2 ** REG_ADDR_W;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    localparam logic [REG_W-1:0]      ZERO_WORD = '0;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = '0;

endpackage

// File: rtl/regfile_if.sv
// Write-back, read-port and HI/LO bundle between pipeline and regfile.
// master: pipeline side (drives writes/addresses); slave: regfile.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
);

    logic [ADDR_W-1:0] wb_wd;
    logic              wb_wreg;
    logic [DATA_W-1:0] wb_wdata;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;

    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    logic              wb_whilo;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output wb_wd, wb_wreg, wb_wdata,
        output re1, raddr1, re2, raddr2,
        output wb_whilo, wb_hi, wb_lo,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata,
        input  re1, raddr1, re2, raddr2,
        input  wb_whilo, wb_hi, wb_lo,
        output rdata1, rdata2, hi_o, lo_o
    );

endinterface

// File: rtl/regfile_hilo_reg.sv
// HI/LO special-register pair with write-through bypass.
// Ports: clk, rst, wb_whilo/wb_hi/wb_lo (write), hi_o/lo_o (read).
module hilo_reg
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // HI and LO always update together.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi <= '0;
            lo <= '0;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi <= wb_hi;
            lo <= wb_lo;
        end
    end

    always_comb begin
        hi_o = hi;
        lo_o = lo;
        if (rst == RST_ENABLE) begin
            hi_o = '0;
            lo_o = '0;
        end else if (wb_whilo == WRITE_ENABLE) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
    end

endmodule

// File: rtl/regfile.sv
// MIPS GPR file: one write-back port, two bypassed combinational reads.
// Ports: clk, rst (sync, active-high), bus (regfile_if.slave).
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              gpr_we;

    assign gpr_we = (bus.wb_wreg == WRITE_ENABLE) &&
                    (bus.wb_wd != ADDR_W'(REG_ZERO));

    // regs[0] is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (gpr_we) begin
            regs[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_i,
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic              wreg,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (rst_i == RST_ENABLE) begin
            return '0;
        end else if (re == READ_DISABLE) begin
            return '0;
        end else if (addr == ADDR_W'(REG_ZERO)) begin
            return '0;
        end else if (wreg == WRITE_ENABLE && wd == addr) begin
            // Same-cycle write-back is forwarded to ID.
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    assign bus.rdata1 = read_port(rst, bus.re1, bus.raddr1,
                                  bus.wb_wreg, bus.wb_wd,
                                  bus.wb_wdata, regs[bus.raddr1]);

    assign bus.rdata2 = read_port(rst, bus.re2, bus.raddr2,
                                  bus.wb_wreg, bus.wb_wd,
                                  bus.wb_wdata, regs[bus.raddr2]);

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk      (clk),
        .rst      (rst),
        .wb_whilo (bus.wb_whilo),
        .wb_hi    (bus.wb_hi),
        .wb_lo    (bus.wb_lo),
        .hi_o     (bus.hi_o),
        .lo_o     (bus.lo_o)
    );

endmodule
